// File: rtl/elastic_async_operator_if.sv
// Channel bundle for elastic_async_operator: per-input request/ack with data
// on the producer side, and a per-branch request/ack fork with a shared
// result bus on the consumer side.
interface elastic_async_operator_if #(
  parameter int data_width  = 32,
  parameter int input_size  = 2,
  parameter int output_size = 1
);
  logic [input_size-1:0]            req_l;
  logic [input_size-1:0]            ack_l;
  logic [data_width*input_size-1:0] din;
  logic [output_size-1:0]           req_r;
  logic [output_size-1:0]           ack_r;
  logic [data_width-1:0]            dout;

  // Handshake: on the input side the operator raises req_l[i] as a level
  // ("a slot is free"), and the producer answers with a one-cycle ack_l[i]
  // pulse only while req_l[i] & ~ack_l[i]; din slice i is captured on the
  // clock edge that sees ack_l[i]=1. On the output side each consumer holds
  // req_r[j] as a level ("I want the token"), and the operator answers with
  // exactly one one-cycle ack_r[j] pulse per token; dout is valid while
  // ack_r[j] is high and does not change in that cycle.

  // Environment side: producers and consumers.
  modport master (
    output ack_l, din, req_r,
    input  req_l, ack_r, dout
  );

  // Operator side.
  modport slave (
    input  ack_l, din, req_r,
    output req_l, ack_r, dout
  );
endinterface

// File: rtl/elastic_async_operator.sv
// elastic_async_operator: dataflow operator node with one FIFO per input
// channel, a parameter-selected operation, a result register and an
// independently acknowledged N-way output fork.
// Optional statistics (fire counter, sticky overflow flag) are built when the
// macro ELASTIC_OP_STATS_EN is defined; otherwise those ports do not exist.
module elastic_async_operator #(
  parameter int                    data_width  = 32,
  parameter string                 op          = "add",
  parameter logic [data_width-1:0] immediate   = '0,
  parameter int                    input_size  = 2,
  parameter int                    output_size = 1,
  parameter int                    fifo_depth  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  elastic_async_operator_if.slave bus
`ifdef ELASTIC_OP_STATS_EN
  ,
  output logic [31:0]             tokens,
  output logic                    overflow
`endif
);

  // Operation encoding resolved once at elaboration from the op string.
  typedef enum logic [3:0] {
    OP_PASS, OP_ADD, OP_SUB, OP_MUL, OP_ADDI, OP_SUBI,
    OP_MULI, OP_MIN, OP_MAX, OP_AND, OP_OR, OP_XOR
  } op_e;

  localparam op_e op_sel =
    (op == "pass") ? OP_PASS :
    (op == "add")  ? OP_ADD  :
    (op == "sub")  ? OP_SUB  :
    (op == "mul")  ? OP_MUL  :
    (op == "addi") ? OP_ADDI :
    (op == "subi") ? OP_SUBI :
    (op == "muli") ? OP_MULI :
    (op == "min")  ? OP_MIN  :
    (op == "max")  ? OP_MAX  :
    (op == "and")  ? OP_AND  :
    (op == "or")   ? OP_OR   :
    (op == "xor")  ? OP_XOR  : OP_ADD;

  // Pointers wrap modulo fifo_depth, so any depth (not only powers of two)
  // works; the counter needs one extra code to represent "full".
  localparam int                ptr_w    = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int                cnt_w    = $clog2(fifo_depth + 1);
  localparam logic [cnt_w-1:0]  depth_c  = cnt_w'(fifo_depth);
  localparam logic [ptr_w-1:0]  last_ptr = ptr_w'(fifo_depth - 1);

  // FIFO storage and bookkeeping, one set per input channel.
  logic [data_width-1:0]                mem_q [input_size][fifo_depth];
  logic [data_width-1:0]                mem_d [input_size][fifo_depth];
  logic [input_size-1:0][ptr_w-1:0]     wr_ptr_q, wr_ptr_d;
  logic [input_size-1:0][ptr_w-1:0]     rd_ptr_q, rd_ptr_d;
  logic [input_size-1:0][cnt_w-1:0]     cnt_q, cnt_d;
  logic [input_size-1:0]                req_l_q, req_l_d;

  // Result register and fork state.
  logic [data_width-1:0]                dout_q, dout_d;
  logic                                 valid_q, valid_d;
  logic [output_size-1:0]               served_q, served_d;
  logic [output_size-1:0]               ack_r_q, ack_r_d;

  // Combinational helpers.
  logic [input_size-1:0][data_width-1:0] head;
  logic [input_size-1:0]                 accept;
  logic [input_size-1:0]                 drop;
  logic                                  all_ne;
  logic                                  all_served;
  logic                                  fire;
  logic [data_width-1:0]                 result;

  // Head of every FIFO and whether every FIFO holds at least one token.
  always_comb begin
    all_ne = 1'b1;
    head   = '0;
    for (int i = 0; i < input_size; i++) begin
      head[i] = mem_q[i][rd_ptr_q[i]];
      if (cnt_q[i] == '0) all_ne = 1'b0;
    end
  end

  // A new token may be loaded only once every branch has taken the old one.
  assign all_served = &served_q;
  assign fire       = all_ne && (!valid_q || all_served);

  // Apply the selected operation to the FIFO heads; arithmetic is unsigned
  // and truncated to data_width.
  always_comb begin
    result = head[0];
    case (op_sel)
      OP_PASS: result = head[0];
      OP_ADD:  for (int i = 1; i < input_size; i++) result = result + head[i];
      OP_SUB:  for (int i = 1; i < input_size; i++) result = result - head[i];
      OP_MUL:  for (int i = 1; i < input_size; i++) result = result * head[i];
      OP_ADDI: result = head[0] + immediate;
      OP_SUBI: result = head[0] - immediate;
      OP_MULI: result = head[0] * immediate;
      OP_MIN:  for (int i = 1; i < input_size; i++) if (head[i] < result) result = head[i];
      OP_MAX:  for (int i = 1; i < input_size; i++) if (head[i] > result) result = head[i];
      OP_AND:  for (int i = 1; i < input_size; i++) result = result & head[i];
      OP_OR:   for (int i = 1; i < input_size; i++) result = result | head[i];
      OP_XOR:  for (int i = 1; i < input_size; i++) result = result ^ head[i];
      default: result = head[0];
    endcase
  end

  // Per-channel FIFO update: push on ack_l, pop on fire, and compute the
  // next request from the occupancy left after this edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    req_l_d  = '0;
    accept   = '0;
    drop     = '0;
    for (int i = 0; i < input_size; i++) begin
      // A push into a full FIFO is a producer protocol error; the token is
      // discarded rather than corrupting the queue.
      accept[i] = bus.ack_l[i] && (cnt_q[i] != depth_c);
      drop[i]   = bus.ack_l[i] && (cnt_q[i] == depth_c);
      if (accept[i]) begin
        mem_d[i][wr_ptr_q[i]] = bus.din[data_width*i +: data_width];
        wr_ptr_d[i] = (wr_ptr_q[i] == last_ptr) ? '0 : wr_ptr_q[i] + 1'b1;
      end
      if (fire) begin
        rd_ptr_d[i] = (rd_ptr_q[i] == last_ptr) ? '0 : rd_ptr_q[i] + 1'b1;
      end
      case ({accept[i], fire})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
      // Dropping req for the cycle after an ack keeps a producer from
      // acking twice against a single free slot.
      req_l_d[i] = (cnt_d[i] != depth_c) && !bus.ack_l[i];
    end
  end

  // Result register and fork: load on fire, otherwise hand the held token to
  // each requesting branch exactly once and retire it when all have it.
  always_comb begin
    dout_d   = dout_q;
    valid_d  = valid_q;
    served_d = served_q;
    ack_r_d  = '0;
    if (fire) begin
      dout_d   = result;
      valid_d  = 1'b1;
      served_d = '0;
    end else begin
      if (valid_q && all_served) begin
        valid_d  = 1'b0;
        served_d = '0;
      end
      for (int j = 0; j < output_size; j++) begin
        if (valid_q && !served_q[j] && bus.req_r[j]) begin
          ack_r_d[j]  = 1'b1;
          served_d[j] = 1'b1;
        end
      end
    end
  end

  // Control state; reset empties every FIFO and abandons the held token.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      req_l_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      served_q <= '0;
      ack_r_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      req_l_q  <= req_l_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      served_q <= served_d;
      ack_r_q  <= ack_r_d;
    end
  end

  // FIFO payload storage; contents are don't-care while the counters say empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.req_l = req_l_q;
  assign bus.ack_r = ack_r_q;
  assign bus.dout  = dout_q;

`ifdef ELASTIC_OP_STATS_EN
  logic [31:0] tokens_q, tokens_d;
  logic        overflow_q, overflow_d;

  // Fire counter wraps naturally; the overflow flag is sticky until reset.
  always_comb begin
    tokens_d   = tokens_q + {31'd0, fire};
    overflow_d = overflow_q | (|drop);
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tokens_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      tokens_q   <= tokens_d;
      overflow_q <= overflow_d;
    end
  end

  assign tokens   = tokens_q;
  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_elastic_async_operator.sv
// Directed bench for elastic_async_operator: add path with throughput,
// immediate wrap-around, back-pressure, asynchronous mid-stream reset and an
// independently acknowledged three-way fork.
`timescale 1ns/1ps
module tb_elastic_async_operator;
  localparam int W    = 32;
  localparam int NTOK = 5000;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Add path state.
  int          add_sent0, add_sent1, add_recv, cyc, t_a, t_b;
  logic [W-1:0] add_exp_q[$];
  logic [W-1:0] e_v;

  // Fork DUT state.
  logic [W-1:0] fk_exp_q[$];
  int           fk_sent[2];
  int           fk_acks[3];
  logic [2:0]   fk_served;
  bit           fk_en;
  logic [W-1:0] fk_base;

  elastic_async_operator_if #(.data_width(W), .input_size(2), .output_size(1)) if_add ();
  elastic_async_operator_if #(.data_width(W), .input_size(2), .output_size(3)) if_fk ();
  elastic_async_operator_if #(.data_width(W), .input_size(1), .output_size(1)) if_addi ();
  elastic_async_operator_if #(.data_width(W), .input_size(1), .output_size(1)) if_muli ();

`ifdef ELASTIC_OP_STATS_EN
  logic [31:0] add_tokens, fk_tokens, addi_tokens, muli_tokens;
  logic        add_overflow, fk_overflow, addi_overflow, muli_overflow;
`endif

  elastic_async_operator #(.data_width(W), .op("add"), .immediate(32'd0),
    .input_size(2), .output_size(1), .fifo_depth(2)) u_add (
    .clk(clk), .rst(rst), .bus(if_add.slave)
`ifdef ELASTIC_OP_STATS_EN
    , .tokens(add_tokens), .overflow(add_overflow)
`endif
  );

  elastic_async_operator #(.data_width(W), .op("sub"), .immediate(32'd0),
    .input_size(2), .output_size(3), .fifo_depth(4)) u_fk (
    .clk(clk), .rst(rst), .bus(if_fk.slave)
`ifdef ELASTIC_OP_STATS_EN
    , .tokens(fk_tokens), .overflow(fk_overflow)
`endif
  );

  elastic_async_operator #(.data_width(W), .op("addi"), .immediate(32'd2),
    .input_size(1), .output_size(1), .fifo_depth(2)) u_addi (
    .clk(clk), .rst(rst), .bus(if_addi.slave)
`ifdef ELASTIC_OP_STATS_EN
    , .tokens(addi_tokens), .overflow(addi_overflow)
`endif
  );

  elastic_async_operator #(.data_width(W), .op("muli"), .immediate(32'd3),
    .input_size(1), .output_size(1), .fifo_depth(2)) u_muli (
    .clk(clk), .rst(rst), .bus(if_muli.slave)
`ifdef ELASTIC_OP_STATS_EN
    , .tokens(muli_tokens), .overflow(muli_overflow)
`endif
  );

  // Scoreboard comparison.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One immediate-op vector: push v once, wait for the ack, compare dout.
  task automatic imm_vec(input bit use_muli, input logic [W-1:0] v,
                         input logic [W-1:0] e, input string tag);
    int   n;
    logic rq;
    logic ak;
    n = 0;
    @(negedge clk);
    rq = use_muli ? if_muli.req_l[0] : if_addi.req_l[0];
    while (rq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      rq = use_muli ? if_muli.req_l[0] : if_addi.req_l[0];
    end
    check({tag, "_req"}, 64'(rq), 64'd1);
    if (use_muli) begin
      if_muli.ack_l[0] = 1'b1;
      if_muli.din      = v;
    end else begin
      if_addi.ack_l[0] = 1'b1;
      if_addi.din      = v;
    end
    @(negedge clk);
    if (use_muli) if_muli.ack_l[0] = 1'b0;
    else          if_addi.ack_l[0] = 1'b0;
    n  = 0;
    ak = use_muli ? if_muli.ack_r[0] : if_addi.ack_r[0];
    while (ak !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      ak = use_muli ? if_muli.ack_r[0] : if_addi.ack_r[0];
    end
    check({tag, "_ack"}, 64'(ak), 64'd1);
    check(tag, 64'(use_muli ? if_muli.dout : if_addi.dout), 64'(e));
  endtask

  // One cycle of the fork DUT: score any acks, then drive both producers.
  task automatic fk_cycle();
    logic [W-1:0] e;
    @(negedge clk);
    for (int j = 0; j < 3; j++) if (if_fk.ack_r[j] === 1'b1) fk_acks[j]++;
    if (if_fk.ack_r !== 3'b000) begin
      check("fk_double_ack", 64'(if_fk.ack_r & fk_served), 64'd0);
      e = (fk_exp_q.size() != 0) ? fk_exp_q[0] : 'x;
      check("fk_dout", 64'(if_fk.dout), 64'(e));
      fk_served = fk_served | if_fk.ack_r;
      if (fk_served == 3'b111) begin
        if (fk_exp_q.size() != 0) void'(fk_exp_q.pop_front());
        fk_served = 3'b000;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (fk_en && if_fk.req_l[i] === 1'b1 && if_fk.ack_l[i] === 1'b0) begin
        if_fk.ack_l[i] = 1'b1;
        if (i == 0) begin
          if_fk.din[W-1:0] = fk_base + W'(3 * fk_sent[0]);
        end else begin
          if_fk.din[2*W-1:W] = W'(fk_sent[1]);
          fk_exp_q.push_back(fk_base + W'(2 * fk_sent[1]));
        end
        fk_sent[i]++;
      end else begin
        if_fk.ack_l[i] = 1'b0;
      end
    end
  endtask

  initial begin
    if_add.ack_l  = '0; if_add.din  = '0; if_add.req_r  = '0;
    if_fk.ack_l   = '0; if_fk.din   = '0; if_fk.req_r   = '0;
    if_addi.ack_l = '0; if_addi.din = '0; if_addi.req_r = '0;
    if_muli.ack_l = '0; if_muli.din = '0; if_muli.req_r = '0;
    fk_served = '0; fk_en = 1'b0; fk_base = 32'd100;
    fk_sent = '{0, 0}; fk_acks = '{0, 0, 0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_add_req_l", 64'(if_add.req_l), 64'd0);
    check("rst_add_ack_r", 64'(if_add.ack_r), 64'd0);
    check("rst_add_dout",  64'(if_add.dout),  64'd0);
    check("rst_fk_req_l",  64'(if_fk.req_l),  64'd0);
    check("rst_fk_dout",   64'(if_fk.dout),   64'd0);
    rst = 1'b1;

    // Immediate ops with wrap-around.
    if_addi.req_r = 1'b1;
    if_muli.req_r = 1'b1;
    imm_vec(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, "addi_wrap");
    imm_vec(1'b0, 32'h0000_0005, 32'h0000_0007, "addi_small");
    imm_vec(1'b0, 32'hFFFF_FFFE, 32'h0000_0000, "addi_zero");
    imm_vec(1'b1, 32'h6000_0000, 32'h2000_0000, "muli_wrap");
    imm_vec(1'b1, 32'h0000_0007, 32'h0000_0015, "muli_small");
    imm_vec(1'b1, 32'h5555_5556, 32'h0000_0002, "muli_wrap2");

    // Add path: free-running producers and consumer, 5000 tokens.
    if_add.req_r = 1'b1;
    add_sent0 = 0; add_sent1 = 0; add_recv = 0; cyc = 0; t_a = 0; t_b = 0;
    while (add_recv < NTOK && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      if (if_add.ack_r[0] === 1'b1) begin
        if (add_exp_q.size() != 0) e_v = add_exp_q.pop_front();
        else                       e_v = 'x;
        check("add_dout", 64'(if_add.dout), 64'(e_v));
        if (add_recv == 999)  t_a = cyc;
        if (add_recv == 4999) t_b = cyc;
        add_recv++;
      end
      if (if_add.req_l[0] === 1'b1 && if_add.ack_l[0] === 1'b0 && add_sent0 < NTOK) begin
        if_add.ack_l[0]   = 1'b1;
        if_add.din[W-1:0] = W'(add_sent0);
        add_sent0++;
      end else begin
        if_add.ack_l[0] = 1'b0;
      end
      if (if_add.req_l[1] === 1'b1 && if_add.ack_l[1] === 1'b0 && add_sent1 < NTOK) begin
        if_add.ack_l[1]     = 1'b1;
        if_add.din[2*W-1:W] = W'(10 + add_sent1);
        add_exp_q.push_back(W'(add_sent1) + W'(10 + add_sent1));
        add_sent1++;
      end else begin
        if_add.ack_l[1] = 1'b0;
      end
    end
    if_add.ack_l = '0;
    check("add_count",       64'(add_recv), 64'(NTOK));
    check("add_exp_q_empty", 64'(add_exp_q.size()), 64'd0);
    check("add_steady_span", 64'(t_b - t_a), 64'd8000);
`ifdef ELASTIC_OP_STATS_EN
    check("add_tokens", 64'(add_tokens), 64'(NTOK));
`endif

    // Back-pressure: all branches idle for 60 cycles.
    if_fk.req_r = 3'b000;
    fk_en = 1'b1;
    repeat (60) fk_cycle();
    check("bp_accepted0", 64'(fk_sent[0]), 64'd5);
    check("bp_accepted1", 64'(fk_sent[1]), 64'd5);
    check("bp_req_l",     64'(if_fk.req_l), 64'd0);
    check("bp_no_acks",   64'(fk_acks[0] + fk_acks[1] + fk_acks[2]), 64'd0);
    check("bp_dout",      64'(if_fk.dout), 64'd100);
`ifdef ELASTIC_OP_STATS_EN
    check("bp_overflow", 64'(fk_overflow), 64'd0);
`endif

    // Asynchronous reset with 5 tokens buffered.
    fk_en = 1'b0;
    if_fk.ack_l = '0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req_l", 64'(if_fk.req_l), 64'd0);
    check("mid_rst_ack_r", 64'(if_fk.ack_r), 64'd0);
    check("mid_rst_dout",  64'(if_fk.dout),  64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    fk_exp_q.delete();
    fk_served = '0;
    fk_sent = '{0, 0};
    fk_acks = '{0, 0, 0};
    fk_base = 32'd1000;

    // Independent fork: branch 2 held low for 20 cycles.
    if_fk.req_r = 3'b011;
    fk_en = 1'b1;
    repeat (20) fk_cycle();
    check("fork_br0_once", 64'(fk_acks[0]), 64'd1);
    check("fork_br1_once", 64'(fk_acks[1]), 64'd1);
    check("fork_br2_none", 64'(fk_acks[2]), 64'd0);
    check("fork_first_after_rst", 64'(if_fk.dout), 64'd1000);
    if_fk.req_r = 3'b111;
    fk_cycle();
    check("fork_br2_ack", 64'(if_fk.ack_r), 64'b100);
    check("fork_br2_dout", 64'(if_fk.dout), 64'd1000);
    repeat (40) fk_cycle();
    fk_en = 1'b0;
    repeat (20) fk_cycle();
    check("fork_exp_q_empty", 64'(fk_exp_q.size()), 64'd0);
    check("fork_br0_total", 64'(fk_acks[0]), 64'(fk_sent[1]));
    check("fork_br1_total", 64'(fk_acks[1]), 64'(fk_sent[1]));
    check("fork_br2_total", 64'(fk_acks[2]), 64'(fk_sent[1]));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/elastic_async_operator.md
Name: elastic_async_operator

Overview:
Parametrised successor to the single-slot handshake operator used in the arf dataflow graphs. Each input channel has its own FIFO of configurable depth. A wider op set is selectable by parameter. The output forks to N consumers, and each branch is acknowledged independently instead of through one ANDed ack. It drops in wherever an operator, reg, in or out node is instantiated, and lets graph generators absorb path imbalance with FIFO depth instead of chains of reg nodes.

Parameters:
- data_width, 32: token width; all arithmetic truncated to this width, unsigned.
- op, "add": one of "pass","add","sub","mul","addi","subi","muli","min","max","and","or","xor".
- immediate, 0: constant for addi/subi/muli.
- input_size, 2: number of input channels, 1..4. Immediate ops and "pass" require 1.
- output_size, 1: number of fork branches, 1..8.
- fifo_depth, 2: entries per input FIFO, >=1, any integer.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_l  out  input_size  per-input request to upstream producer.
- ack_l  in  input_size  per-input one-cycle ack; data is valid in that cycle.
- din  in  data_width*input_size  input data; channel i is bits [data_width*(i+1)-1 : data_width*i].
- req_r  in  output_size  per-branch level request from downstream.
- ack_r  out  output_size  per-branch one-cycle ack; dout is valid while it is high.
- dout  out  data_width  result register.

Behaviour:
- Reset (rst=0, asynchronous): req_l=0, ack_r=0, dout=0, all FIFOs empty, valid=0, served=0. The block stays idle until the first clk edge after rst=1.
- Input capture:
  - On any clk edge with ack_l[i]=1, din slice i is pushed into FIFO i. Capture is synchronous only; no capture on ack edges.
  - Next req_l[i] = (free slots in FIFO i after this edge's push/pop >= 1) AND NOT ack_l[i]. This drops req for one cycle after every ack.
  - A full FIFO never raises req. Overflow is therefore impossible with producers that ack only when req & ~ack.
  - Simultaneous push and pop on the same FIFO is legal, and the occupancy count is unchanged.
  - A push while the FIFO is full is a protocol error (see Optional Feature); the data is dropped.
- Fire:
  - Condition: every FIFO is non-empty AND (valid=0 OR served == all ones).
  - Action on that edge: pop the head of every FIFO, load dout = op(heads), set valid=1, clear served.
  - Latency: 1 cycle from the last head becoming available to dout updating.
- Op semantics: in0 is channel 0.
  - sub = in0-in1-...; min and max are unsigned.
  - mul keeps the low data_width bits.
  - Immediate ops use in0 with immediate.
- Output fork:
  - On each edge with valid=1, served[j]=0, req_r[j]=1: ack_r[j]<=1 and served[j]<=1. Otherwise ack_r[j]<=0.
  - Each branch receives exactly one ack per token regardless of how long req_r is held.
  - When served is all ones at an edge, valid clears unless fire reloads dout on that same edge.
  - The ack cycle and the dout update never overlap, because dout reloads only after the served bits are registered.
- Throughput: steady state is one token per 2 cycles per branch, matching the producer/consumer models.
- Boundaries:
  - A branch with req_r permanently low blocks fire once valid=1, and back-pressure propagates to req_l.
  - Occupancy counters saturate between 0 and fifo_depth; read/write pointers wrap modulo fifo_depth.
  - Reset mid-operation discards all queued tokens immediately, with no partial acks.

Optional Feature:
- Macro ELASTIC_OP_STATS_EN.
- When defined:
  - Adds output port tokens (32 bits): count of fire events, wrapping at 2^32.
  - Adds output port overflow (1 bit): sticky flag set on a push into a full FIFO.
  - Both ports clear on reset.
- When undefined: both ports and their counters are absent, and behaviour is otherwise identical.

Test Plan:
- Add path. Config: op=add, input_size=2, fifo_depth=2, output_size=1. Producers send in0=0,1,2,... and in1=10,11,12,... -> dout sequence 10,12,14,..., one ack_r per token, 5000 tokens without loss.
- Reset mid-stream. Config: fifo_depth=4; hold req_r=0 until 5 tokens are buffered, then pulse rst low for 1 cycle -> req_l=0, ack_r=0, dout=0 at once. After release, the first dout equals the first token pushed after reset.
- Independent fork. Config: output_size=3; branch 2 holds req_r low for 20 cycles -> branches 0 and 1 each get exactly one ack for token 0. The next token is not loaded until branch 2 is acked, and then ack_r[2] pulses once.
- Back-pressure. Config: fifo_depth=4; all req_r low for 60 cycles -> exactly 5 tokens accepted per input (4 queued + 1 in dout). req_l stays 0 afterwards, and overflow (stats build) stays 0.
- Immediate wrap. Config: op=addi, immediate=2, input_size=1; input 32'hFFFFFFFF -> dout=1. With op=muli, immediate=3 and input 32'h60000000 -> dout=32'h20000000.
- Throughput and stats. No stalls, 5000 tokens -> one ack every 2 cycles in steady state, measured throughput >= 99% of the 4-cycle reference metric, and tokens=5000 (stats build).
